jk_cmd_driver: RTL and testbench
================================

// Module: jk_cmd_driver
// PURPOSE
//   Command-side driver for a bank of N jk_ff storage flops (valve/pump latches in the irrigation
//   controller). Accepts a target-pattern request over a valid/ready handshake and derives per-bit
//   J/K excitation from the bank's Q feedback. Drives J/K for one cycle, waits for settle, then
//   verifies Q against the expected pattern. Retries on mismatch and reports ok/err on completion.
// PARAMETERS
//   N           4  number of JK flops driven (bits of target/mask/q_fb/j/k)
//   SETTLE_CYC  2  cycles J=K=0 held after a drive before Q is checked (legal range 1..15)
//   MAX_RETRY   3  extra drive attempts after a failed check (0 = no retry; legal range 0..7)
// PORTS
//   clk         in   1  clock, all state on posedge
//   rst_n       in   1  reset, synchronous, active-low
//   req_valid   in   1  request present
//   req_ready   out  1  block can accept (high only in IDLE)
//   req_target  in   N  desired Q per bit (load mode)
//   req_mask    in   N  1 = bit participates; 0 = bit never driven (J=K=0)
//   req_toggle  in   1  1 = toggle masked bits (expected = ~Q at accept); 0 = load req_target
//   q_fb        in   N  Q outputs of the JK bank
//   j_out       out  N  J inputs to the JK bank (registered)
//   k_out       out  N  K inputs to the JK bank (registered)
//   busy        out  1  high in every state except IDLE
//   done_valid  out  1  one-cycle completion pulse
//   done_ok     out  1  valid with done_valid: masked Q bits matched expected
//   done_err    out  1  valid with done_valid: retries exhausted; done_ok=0
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE; j_out=k_out=0, busy=0, done_valid=done_ok=done_err=0,
//     retry count=0. Reset in any state aborts the request with no done pulse.
//   Handshake: accept when req_valid && req_ready at a posedge. Latch mask, toggle flag and
//     expected (load: req_target; toggle: ~q_fb) at that edge. req_ready=0 from the next cycle
//     until IDLE returns. The block never stalls a request presented in IDLE.
//   FSM: IDLE -> DRIVE -> SETTLE -> CHECK -> DONE -> IDLE; CHECK -> DRIVE on retry.
//     DRIVE  (exactly 1 cycle): j_out/k_out hold the excitation.
//       First attempt in toggle mode: masked bits J=K=1.
//       Load mode, and every retry in either mode, uses per-bit set/reset against current q_fb:
//         q=0,t=0 -> 00; q=0,t=1 -> 10; q=1,t=1 -> 00; q=1,t=0 -> 01.
//       The retry path never emits 11. Unmasked bits are always 00.
//     SETTLE (SETTLE_CYC cycles): j_out=k_out=0; down-counter loaded on DRIVE exit.
//     CHECK  (1 cycle): match = ((q_fb ^ expected) & mask) == 0.
//       match -> DONE ok. mismatch && retries<MAX_RETRY -> retries++, DRIVE.
//       Otherwise -> DONE err.
//     DONE   (1 cycle): done_valid=1 with done_ok/done_err. Both are 0 outside DONE. Next state IDLE.
//   Latency: accept at edge E; DRIVE cycle E+1; CHECK at E+2+SETTLE_CYC.
//     done_valid in cycle E+3+SETTLE_CYC when no retry.
//     Each retry adds SETTLE_CYC+2 cycles.
//     Earliest next accept: edge ending the DONE cycle+1 (IDLE cycle).
//   Boundaries: mask=0 runs the full sequence with all-00 drive and reports ok.
//     Expected already equal to Q: drive 00, ok.
//     j_out/k_out are 0 in every state but DRIVE.
//     Retry counter saturates; it is cleared on accept.
// STRUCTURE
//   jk_pkg:
//     state encoding (IDLE/DRIVE/SETTLE/CHECK/DONE)
//     JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11
//     function jk_excite(q,t) returning {j,k}
//   Sub-module jk_excite_enc: combinational, N-wide, per-bit set/reset encode of
//     (q_fb, expected, mask, toggle_first) -> {j,k}. Outputs are registered in the top.
// TESTING
//   Bench models N jk_ff instances driven by j_out/k_out, with q_fb wired from their q.
//   1 Load from Q=0000: target=1010, mask=1111 -> DRIVE j=1010, k=0000; done_ok at E+5 (SETTLE=2); Q=1010.
//   2 Toggle: Q=0110, mask=0011, toggle=1 -> DRIVE j=k=0011; Q=0101; done_ok=1.
//   3 Stuck bit0 forced 0, target=0001 -> 1+MAX_RETRY drives (4), each j=0001; done_err=1 at E+5+3*4.
//   4 Bit stuck for first check only -> one retry with 10/01 encoding (no 11); done_ok=1.
//   5 mask=0000 -> j=k=0 throughout; done_ok=1; Q unchanged.
//   6 rst_n=0 during SETTLE -> next cycle IDLE, req_ready=1, all outputs 0, no done pulse.
//     Back-to-back request accepted in the first IDLE cycle.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and J/K excitation encoding for the JK-bank command driver.
package jk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    localparam int unsigned SETTLE_W = 4;
    localparam int unsigned RETRY_W  = 3;

    // Set/reset excitation moving q toward t; never returns JK_TOG.
    function automatic logic [1:0] jk_excite(input logic q, input logic t);
        logic [1:0] jk;
        if (q == t) begin
            jk = JK_HOLD;
        end else if (t) begin
            jk = JK_SET;
        end else begin
            jk = JK_RST;
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// Per-bit J/K encoder: toggle on a first toggle-mode attempt, otherwise set/reset toward expected.
module jk_excite_enc
    import jk_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] q_fb,
    input  logic [N-1:0] expected,
    input  logic [N-1:0] mask,
    input  logic         toggle_first,
    output logic [N-1:0] j,
    output logic [N-1:0] k
);

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (mask[i]) begin
                if (toggle_first) begin
                    {j[i], k[i]} = JK_TOG;
                end else begin
                    {j[i], k[i]} = jk_excite(q_fb[i], expected[i]);
                end
            end
        end
    end

endmodule

// File: rtl/jk_cmd_driver.sv
// Drives a JK flop bank to a requested pattern, verifies Q after settling, retries, reports ok/err.
module jk_cmd_driver
    import jk_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_target,
    input  logic [N-1:0] req_mask,
    input  logic         req_toggle,
    input  logic [N-1:0] q_fb,
    output logic [N-1:0] j_out,
    output logic [N-1:0] k_out,
    output logic         busy,
    output logic         done_valid,
    output logic         done_ok,
    output logic         done_err
);

    state_t              state, state_nxt;
    logic [N-1:0]        exp_q, exp_nxt;
    logic [N-1:0]        mask_q, mask_nxt;
    logic [SETTLE_W-1:0] cnt_q, cnt_nxt;
    logic [RETRY_W-1:0]  retry_q, retry_nxt;
    logic [N-1:0]        j_nxt, k_nxt;
    logic                ready_nxt, busy_nxt;
    logic                dv_nxt, dok_nxt, derr_nxt;

    logic                accept;
    logic                match;
    logic [N-1:0]        enc_exp, enc_mask, enc_j, enc_k;
    logic                enc_tog;

    assign accept = req_valid && req_ready;
    assign match  = ((q_fb ^ exp_q) & mask_q) == '0;

    // In IDLE the encoder sees the incoming request; otherwise the latched retry context.
    assign enc_exp  = (state == IDLE) ? (req_toggle ? ~q_fb : req_target) : exp_q;
    assign enc_mask = (state == IDLE) ? req_mask : mask_q;
    assign enc_tog  = (state == IDLE) && req_toggle;

    jk_excite_enc #(.N(N)) u_enc (
        .q_fb         (q_fb),
        .expected     (enc_exp),
        .mask         (enc_mask),
        .toggle_first (enc_tog),
        .j            (enc_j),
        .k            (enc_k)
    );

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_q;
        mask_nxt  = mask_q;
        cnt_nxt   = cnt_q;
        retry_nxt = retry_q;
        j_nxt     = '0;
        k_nxt     = '0;
        dv_nxt    = 1'b0;
        dok_nxt   = 1'b0;
        derr_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    exp_nxt   = enc_exp;
                    mask_nxt  = req_mask;
                    retry_nxt = '0;
                    j_nxt     = enc_j;
                    k_nxt     = enc_k;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                cnt_nxt   = SETTLE_W'(SETTLE_CYC - 1);
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_nxt = CHECK;
                end else begin
                    cnt_nxt = cnt_q - SETTLE_W'(1);
                end
            end
            CHECK: begin
                if (match) begin
                    dv_nxt    = 1'b1;
                    dok_nxt   = 1'b1;
                    state_nxt = DONE;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_nxt = retry_q + RETRY_W'(1);
                    j_nxt     = enc_j;
                    k_nxt     = enc_k;
                    state_nxt = DRIVE;
                end else begin
                    dv_nxt    = 1'b1;
                    derr_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            exp_q      <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            j_out      <= '0;
            k_out      <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done_valid <= 1'b0;
            done_ok    <= 1'b0;
            done_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            exp_q      <= exp_nxt;
            mask_q     <= mask_nxt;
            cnt_q      <= cnt_nxt;
            retry_q    <= retry_nxt;
            j_out      <= j_nxt;
            k_out      <= k_nxt;
            req_ready  <= ready_nxt;
            busy       <= busy_nxt;
            done_valid <= dv_nxt;
            done_ok    <= dok_nxt;
            done_err   <= derr_nxt;
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Scoreboard bench for jk_cmd_driver with a behavioural JK bank on q_fb.
module tb_jk_cmd_driver;

    localparam int unsigned N = 4;

    typedef struct {
        logic         ok;
        logic         err;
        int           lat;
        int           ndrv;
        logic [N-1:0] fj, fk, lj, lk, qf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid, req_ready, req_toggle;
    logic [N-1:0] req_target, req_mask, q_fb, j_out, k_out;
    logic         busy, done_valid, done_ok, done_err;

    logic [N-1:0] qm = '0;
    logic [N-1:0] stk_en = '0;
    logic [N-1:0] stk_val = '0;
    logic [N-1:0] frz = '0;

    exp_t sbq[$];
    int   nvec = 0, nfail = 0, ndone = 0, tmo = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;
    logic fin_req = 1'b0, fin_ack = 1'b0;

    logic         active = 1'b0;
    int           acc = 0, nd = 0;
    logic [N-1:0] fj, fk, lj, lk;
    logic         r11;
    exp_t         e;

    jk_cmd_driver #(.N(N), .SETTLE_CYC(2), .MAX_RETRY(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .req_mask   (req_mask),
        .req_toggle (req_toggle),
        .q_fb       (q_fb),
        .j_out      (j_out),
        .k_out      (k_out),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ok    (done_ok),
        .done_err   (done_err)
    );

    always #5 clk = ~clk;

    // JK bank model; stk_* forces feedback bits, frz blocks flop updates.
    assign q_fb = (qm & ~stk_en) | (stk_val & stk_en);

    always @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            if (!frz[i]) begin
                case ({j_out[i], k_out[i]})
                    2'b01:   qm[i] <= 1'b0;
                    2'b10:   qm[i] <= 1'b1;
                    2'b11:   qm[i] <= ~qm[i];
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: reset-state checks, drive capture, scoreboard compare on done.
    always @(negedge clk) begin
        if (!rst_q) begin
            chk("rst_req_ready", 32'(req_ready), 32'(1));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_j_out", 32'(j_out), 32'(0));
            chk("rst_k_out", 32'(k_out), 32'(0));
            chk("rst_done_valid", 32'(done_valid), 32'(0));
            chk("rst_done_ok", 32'(done_ok), 32'(0));
            chk("rst_done_err", 32'(done_err), 32'(0));
            active = 1'b0;
        end else begin
            if (active && ((j_out | k_out) != '0)) begin
                if (nd == 0) begin
                    fj = j_out;
                    fk = k_out;
                end else if ((j_out & k_out) != '0) begin
                    r11 = 1'b1;
                end
                lj = j_out;
                lk = k_out;
                nd++;
            end
            if (done_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("done_ok", 32'(done_ok), 32'(e.ok));
                    chk("done_err", 32'(done_err), 32'(e.err));
                    chk("latency", 32'(cyc - acc + 1), 32'(e.lat));
                    chk("drive_count", 32'(nd), 32'(e.ndrv));
                    chk("first_j", 32'(fj), 32'(e.fj));
                    chk("first_k", 32'(fk), 32'(e.fk));
                    chk("last_j", 32'(lj), 32'(e.lj));
                    chk("last_k", 32'(lk), 32'(e.lk));
                    chk("final_q", 32'(q_fb), 32'(e.qf));
                    chk("retry_no_11", 32'(r11), 32'(0));
                end
                ndone++;
                active = 1'b0;
            end
        end
        if (rst_n && req_valid && req_ready) begin
            active = 1'b1;
            acc    = cyc + 1;
            nd     = 0;
            fj     = '0;
            fk     = '0;
            lj     = '0;
            lk     = '0;
            r11    = 1'b0;
        end
        if (fin_req && !fin_ack) begin
            chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
            chk("wait_timeouts", 32'(tmo), 32'(0));
            fin_ack = 1'b1;
        end
    end

    function automatic exp_t mk(input logic ok, input logic err, input int lat, input int ndrv,
                                input logic [N-1:0] fj_e, input logic [N-1:0] fk_e,
                                input logic [N-1:0] lj_e, input logic [N-1:0] lk_e,
                                input logic [N-1:0] qf_e);
        exp_t r;
        r.ok = ok; r.err = err; r.lat = lat; r.ndrv = ndrv;
        r.fj = fj_e; r.fk = fk_e; r.lj = lj_e; r.lk = lk_e; r.qf = qf_e;
        return r;
    endfunction

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send(input logic [N-1:0] tgt, input logic [N-1:0] msk, input logic tog,
                        input logic push, input exp_t ex);
        int n;
        n = 0;
        if (push) sbq.push_back(ex);
        req_target = tgt;
        req_mask   = msk;
        req_toggle = tog;
        req_valid  = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) tmo++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (ndone < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (ndone < target) tmo++;
        #1;
    endtask

    initial begin
        exp_t none;
        int   n;
        none = mk(1'b0, 1'b0, 0, 0, '0, '0, '0, '0, '0);
        req_valid  = 1'b0;
        req_target = '0;
        req_mask   = '0;
        req_toggle = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Load 1010 from 0000.
        send(4'b1010, 4'b1111, 1'b0, 1'b1, mk(1, 0, 5, 1, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1010));
        wait_done(1);
        // Load 0110 from 1010, issued in the first IDLE cycle.
        send(4'b0110, 4'b1111, 1'b0, 1'b1, mk(1, 0, 5, 1, 4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0110));
        wait_done(2);
        // Toggle low two bits of 0110.
        send(4'b0000, 4'b0011, 1'b1, 1'b1, mk(1, 0, 5, 1, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0101));
        wait_done(3);
        // Bit0 feedback stuck at 0: four identical drives, then error.
        stk_en = 4'b0001; stk_val = 4'b0000;
        send(4'b0001, 4'b0001, 1'b0, 1'b1, mk(0, 1, 17, 4, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0100));
        wait_done(4);
        stk_en = 4'b0000;
        // Bit1 ignores the first drive only: one set/reset retry.
        frz = 4'b0010;
        send(4'b0010, 4'b0011, 1'b0, 1'b1, mk(1, 0, 9, 2, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0110));
        @(posedge clk);
        #1 frz = 4'b0000;
        wait_done(5);
        // Empty mask in load and toggle mode.
        send(4'b1111, 4'b0000, 1'b0, 1'b1, mk(1, 0, 5, 0, '0, '0, '0, '0, 4'b0110));
        wait_done(6);
        send(4'b1111, 4'b0000, 1'b1, 1'b1, mk(1, 0, 5, 0, '0, '0, '0, '0, 4'b0110));
        wait_done(7);
        // Target already equal to Q.
        send(4'b0110, 4'b1111, 1'b0, 1'b1, mk(1, 0, 5, 0, '0, '0, '0, '0, 4'b0110));
        wait_done(8);
        // Abort in SETTLE (drive already landed: Q=1001), then immediate new request.
        send(4'b1001, 4'b1111, 1'b0, 1'b0, none);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(4'b0000, 4'b1111, 1'b0, 1'b1, mk(1, 0, 5, 1, 4'b0000, 4'b1001, 4'b0000, 4'b1001, 4'b0000));
        wait_done(9);

        repeat (4) @(posedge clk);
        fin_req = 1'b1;
        n = 0;
        while (!fin_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
